// File: rtl/decoder_pkg.sv
// Shared decoder definitions: address/message width derivation and the union message layout
// carried between stage controllers over the link channels.
package decoder_pkg;

    function automatic int address_width(input int code_distance);
        return 3 * $clog2(code_distance);
    endfunction

    function automatic int msg_width(input int code_distance);
        return 2 * address_width(code_distance) + 2;
    endfunction

    localparam int SC_CODE_DISTANCE = 5;
    localparam int SC_ADDRESS_WIDTH = address_width(SC_CODE_DISTANCE);
    localparam int SC_MSG_WIDTH     = msg_width(SC_CODE_DISTANCE);
    localparam int STAGE_WIDTH      = 3;

    typedef struct packed {
        logic [SC_ADDRESS_WIDTH-1:0] old_root;
        logic [SC_ADDRESS_WIDTH-1:0] updated_root;
        logic [1:0]                  flags;
    } sc_msg_t;

endpackage

// File: rtl/sc_link_fifo.sv
// First-word fall-through FIFO with wrap-bit pointers; the head entry is visible on rd_data
// whenever not_empty is high, and reads as zero when empty.
module sc_link_fifo #(
    parameter int WIDTH = 20,
    parameter int DEPTH = 16
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             wr_en,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             rd_en,
    output logic [WIDTH-1:0] rd_data,
    output logic             not_empty,
    output logic             full
);
    localparam int PW = $clog2(DEPTH);

    logic [PW:0]      wr_ptr_q, wr_ptr_d;
    logic [PW:0]      rd_ptr_q, rd_ptr_d;
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic             empty;
    logic             pop;

    assign empty     = (wr_ptr_q == rd_ptr_q);
    assign full      = (wr_ptr_q[PW] != rd_ptr_q[PW]) && (wr_ptr_q[PW-1:0] == rd_ptr_q[PW-1:0]);
    assign not_empty = !empty;
    assign pop       = rd_en && !empty;
    assign rd_data   = empty ? '0 : mem_q[rd_ptr_q[PW-1:0]];

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (wr_en) wr_ptr_d = wr_ptr_q + 1'b1;
        if (pop)   rd_ptr_d = rd_ptr_q + 1'b1;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    // Storage is deliberately not reset; the pointers alone define what is valid.
    always_ff @(posedge clk) begin
        if (wr_en) mem_q[wr_ptr_q[PW-1:0]] <= wr_data;
    end

    // Credits upstream make this unreachable; catching it means the credit counter is broken.
    always @(posedge clk) begin
        if (reset_n) assert (!(wr_en && full));
    end

endmodule

// File: rtl/sc_link_channel.sv
// Fixed-latency inter-FPGA link model: delay line into a credit-protected FWFT FIFO.
// Optional statistics ports are compiled in when SC_LINK_STATS_EN is defined.
module sc_link_channel
    import decoder_pkg::*;
#(
    parameter int CODE_DISTANCE = 5,
    parameter int MSG_WIDTH     = msg_width(CODE_DISTANCE),
    parameter int DEPTH         = 16,
    parameter int LINK_LATENCY  = 4
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic [MSG_WIDTH-1:0]   in_data,
    input  logic                   in_valid,
    output logic                   in_ready,
    output logic [MSG_WIDTH-1:0]   out_data,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic                   message_flying,
    output logic [$clog2(DEPTH):0] occupancy
`ifdef SC_LINK_STATS_EN
    ,
    output logic [31:0]            msg_count,
    output logic [$clog2(DEPTH):0] peak_occupancy,
    output logic [31:0]            stall_cycles
`endif
);
    localparam int OW = $clog2(DEPTH) + 1;
    localparam logic [OW-1:0] CREDITS = OW'(DEPTH);

    logic [OW-1:0]        occupancy_q, occupancy_d;
    logic                 accept;
    logic                 pop;
    logic                 fifo_wr_en;
    logic [MSG_WIDTH-1:0] fifo_wr_data;
    logic                 fifo_not_empty;
    logic                 fifo_full;

    // in_ready is gated by reset_n so it reads 0 while reset is held.
    assign in_ready       = reset_n && (occupancy_q < CREDITS);
    assign accept         = in_valid && in_ready;
    assign pop            = fifo_not_empty && out_ready;
    assign out_valid      = fifo_not_empty;
    assign occupancy      = occupancy_q;
    assign message_flying = (occupancy_q != '0);

    for (genvar gi = 0; gi < LINK_LATENCY; gi++) begin : g_stage
        logic                 valid_q, valid_d;
        logic [MSG_WIDTH-1:0] data_q, data_d;

        if (gi == 0) begin : g_first
            always_comb begin
                valid_d = accept;
                data_d  = in_data;
            end
        end else begin : g_next
            always_comb begin
                valid_d = g_stage[gi-1].valid_q;
                data_d  = g_stage[gi-1].data_q;
            end
        end

        always_ff @(posedge clk or negedge reset_n) begin
            if (!reset_n) begin
                valid_q <= 1'b0;
                data_q  <= '0;
            end else begin
                valid_q <= valid_d;
                data_q  <= data_d;
            end
        end
    end

    assign fifo_wr_en   = g_stage[LINK_LATENCY-1].valid_q;
    assign fifo_wr_data = g_stage[LINK_LATENCY-1].data_q;

    sc_link_fifo #(
        .WIDTH (MSG_WIDTH),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk       (clk),
        .reset_n   (reset_n),
        .wr_en     (fifo_wr_en),
        .wr_data   (fifo_wr_data),
        .rd_en     (pop),
        .rd_data   (out_data),
        .not_empty (fifo_not_empty),
        .full      (fifo_full)
    );

    always_comb begin
        occupancy_d = occupancy_q;
        if (accept && !pop)      occupancy_d = occupancy_q + 1'b1;
        else if (!accept && pop) occupancy_d = occupancy_q - 1'b1;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) occupancy_q <= '0;
        else          occupancy_q <= occupancy_d;
    end

`ifdef SC_LINK_STATS_EN
    logic [31:0]   msg_count_q, msg_count_d;
    logic [OW-1:0] peak_q, peak_d;
    logic [31:0]   stall_q, stall_d;

    always_comb begin
        msg_count_d = msg_count_q;
        peak_d      = peak_q;
        stall_d     = stall_q;
        if (pop && (msg_count_q != '1))                msg_count_d = msg_count_q + 1'b1;
        if (occupancy_d > peak_q)                      peak_d      = occupancy_d;
        if (in_valid && !in_ready && (stall_q != '1))  stall_d     = stall_q + 1'b1;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            msg_count_q <= '0;
            peak_q      <= '0;
            stall_q     <= '0;
        end else begin
            msg_count_q <= msg_count_d;
            peak_q      <= peak_d;
            stall_q     <= stall_d;
        end
    end

    assign msg_count      = msg_count_q;
    assign peak_occupancy = peak_q;
    assign stall_cycles   = stall_q;
`endif

endmodule

// File: tb/tb_sc_link_channel.sv
// Self-checking bench for sc_link_channel: table vectors, directed corner sequences and a
// randomized run against a queue-based reference of the channel's timing and ordering rules.
module tb_sc_link_channel;
    import decoder_pkg::*;

    localparam int MW    = 20;
    localparam int DEPTH = 16;
    localparam int LAT   = 4;
    localparam int OW    = 5;

    logic          clk = 1'b0;
    logic          reset_n = 1'b0;
    logic [MW-1:0] in_data = '0;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [MW-1:0] out_data;
    logic          out_valid;
    logic          out_ready = 1'b0;
    logic          message_flying;
    logic [OW-1:0] occupancy;
`ifdef SC_LINK_STATS_EN
    logic [31:0]   msg_count;
    logic [OW-1:0] peak_occupancy;
    logic [31:0]   stall_cycles;
`endif

    always #5 clk = ~clk;

    sc_link_channel #(
        .CODE_DISTANCE (5),
        .MSG_WIDTH     (MW),
        .DEPTH         (DEPTH),
        .LINK_LATENCY  (LAT)
    ) dut (
        .clk            (clk),
        .reset_n        (reset_n),
        .in_data        (in_data),
        .in_valid       (in_valid),
        .in_ready       (in_ready),
        .out_data       (out_data),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .message_flying (message_flying),
        .occupancy      (occupancy)
`ifdef SC_LINK_STATS_EN
        ,
        .msg_count      (msg_count),
        .peak_occupancy (peak_occupancy),
        .stall_cycles   (stall_cycles)
`endif
    );

    int n_cmp = 0;
    int n_mis = 0;
    int cyc   = 0;

    // Reference: every message in the channel with the cycle it becomes visible at the output.
    typedef struct {
        logic [MW-1:0] d;
        int            rdy;
    } ent_t;
    ent_t mq[$];

    typedef struct {
        bit            iv;
        logic [MW-1:0] id;
        bit            ordy;
        bit            e_ov;
        logic [MW-1:0] e_od;
        int            e_occ;
        bit            e_fly;
    } vec_t;

    function automatic void chk(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_mis++;
            $display("FAIL %s: got 0x%0h required 0x%0h (cycle %0d, t=%0t)", name, act, exp, cyc, $time);
        end
    endfunction

    function automatic bit m_ov();
        return (mq.size() > 0) && (mq[0].rdy <= cyc);
    endfunction

    function automatic bit m_ir();
        return mq.size() < DEPTH;
    endfunction

    task automatic check_model(input string tag);
        chk({tag, ".in_ready"},  int'(in_ready),  int'(m_ir()));
        chk({tag, ".out_valid"}, int'(out_valid), int'(m_ov()));
        if (m_ov()) chk({tag, ".out_data"}, int'(out_data), int'(mq[0].d));
        chk({tag, ".occupancy"}, int'(occupancy), mq.size());
        chk({tag, ".flying"},    int'(message_flying), int'(mq.size() != 0));
    endtask

    task automatic step(input bit iv, input logic [MW-1:0] id, input bit ordy,
                        output bit acc, output bit pop);
        ent_t e;
        in_valid  = iv;
        in_data   = id;
        out_ready = ordy;
        acc = iv && m_ir();
        pop = m_ov() && ordy;
        if (pop) void'(mq.pop_front());
        if (acc) begin
            e.d   = id;
            e.rdy = cyc + LAT + 1;
            mq.push_back(e);
        end
        @(negedge clk);
        cyc++;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t          tv[7];
        bit            acc, pop;
        int            n_acc, n_out, bad, stalls, sent, recv, guard;
        logic [MW-1:0] nxt;
        logic [MW-1:0] got[$];
        sc_msg_t       m;

        // Test 1: reset held, then released
        reset_n = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst.in_ready",  int'(in_ready), 0);
        chk("rst.out_valid", int'(out_valid), 0);
        chk("rst.out_data",  int'(out_data), 0);
        chk("rst.flying",    int'(message_flying), 0);
        chk("rst.occupancy", int'(occupancy), 0);
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        #1;
        chk("idle.in_ready",  int'(in_ready), 1);
        chk("idle.out_valid", int'(out_valid), 0);
        chk("idle.occupancy", int'(occupancy), 0);
        chk("idle.flying",    int'(message_flying), 0);
        mq.delete();
        cyc = 0;

        // Test 2: single message through an empty channel (table driven)
        tv[0] = '{1'b1, 20'h0ABCD, 1'b1, 1'b0, 20'h0, 0, 1'b0};
        tv[1] = '{1'b0, 20'h0,     1'b1, 1'b0, 20'h0, 1, 1'b1};
        tv[2] = '{1'b0, 20'h0,     1'b1, 1'b0, 20'h0, 1, 1'b1};
        tv[3] = '{1'b0, 20'h0,     1'b1, 1'b0, 20'h0, 1, 1'b1};
        tv[4] = '{1'b0, 20'h0,     1'b1, 1'b0, 20'h0, 1, 1'b1};
        tv[5] = '{1'b0, 20'h0,     1'b1, 1'b1, 20'h0ABCD, 1, 1'b1};
        tv[6] = '{1'b0, 20'h0,     1'b1, 1'b0, 20'h0, 0, 1'b0};
        for (int i = 0; i < 7; i++) begin
            chk($sformatf("single[%0d].out_valid", i), int'(out_valid), int'(tv[i].e_ov));
            if (tv[i].e_ov) chk($sformatf("single[%0d].out_data", i), int'(out_data), int'(tv[i].e_od));
            chk($sformatf("single[%0d].occupancy", i), int'(occupancy), tv[i].e_occ);
            chk($sformatf("single[%0d].flying", i), int'(message_flying), int'(tv[i].e_fly));
            chk($sformatf("single[%0d].in_ready", i), int'(in_ready), 1);
            step(tv[i].iv, tv[i].id, tv[i].ordy, acc, pop);
        end

        // Test 3: backpressure fill then ordered drain
        nxt = 20'd1;
        n_acc = 0;
        for (int i = 0; i < 24; i++) begin
            check_model("fill");
            if (in_ready) n_acc++;
            step(1'b1, nxt, 1'b0, acc, pop);
            if (acc) nxt++;
        end
        chk("fill.accepts",   n_acc, 16);
        chk("fill.occupancy", int'(occupancy), 16);
        chk("fill.in_ready",  int'(in_ready), 0);
`ifdef SC_LINK_STATS_EN
        chk("fill.peak", int'(peak_occupancy), 16);
`endif
        for (int i = 0; i < 18; i++) begin
            check_model("drain");
            if (i == 1) chk("drain.in_ready_after_pop", int'(in_ready), 1);
            if (out_valid) got.push_back(out_data);
            step(1'b0, '0, 1'b1, acc, pop);
        end
        chk("drain.count", got.size(), 16);
        for (int k = 0; k < got.size(); k++) chk($sformatf("drain.order[%0d]", k), int'(got[k]), k + 1);

        // Test 4: continuous streaming
        n_out = 0; bad = 0; stalls = 0;
        for (int k = 0; k < 100; k++) begin
            check_model("stream");
            if (out_valid) n_out++;
            if (!in_ready) stalls++;
            if (k >= LAT + 1 && (occupancy != 5 || !out_valid)) bad++;
            step(1'b1, MW'($urandom), 1'b1, acc, pop);
        end
        chk("stream.outputs", n_out, 95);
        chk("stream.steady",  bad, 0);
        chk("stream.stalls",  stalls, 0);
        for (int k = 0; k < 10; k++) begin
            check_model("stream_drain");
            step(1'b0, '0, 1'b1, acc, pop);
        end

        // Test 5: random valid/ready traffic, 1000 messages
        sent = 0; recv = 0; guard = 0;
        while ((sent < 1000 || mq.size() > 0) && guard < 20000) begin
            bit iv, ordy;
            check_model("rand");
            iv   = (sent < 1000) ? bit'($urandom_range(0, 1)) : 1'b0;
            ordy = bit'($urandom_range(0, 1));
            if (out_valid && ordy) recv++;
            m.old_root     = SC_ADDRESS_WIDTH'($urandom);
            m.updated_root = SC_ADDRESS_WIDTH'($urandom);
            m.flags        = 2'($urandom);
            step(iv, m, ordy, acc, pop);
            if (acc) sent++;
            guard++;
        end
        chk("rand.sent",     sent, 1000);
        chk("rand.received", recv, 1000);

        // Test 6: reset with 2 messages in the FIFO and 3 in the delay line
        step(1'b1, 20'h11111, 1'b0, acc, pop);
        step(1'b1, 20'h22222, 1'b0, acc, pop);
        step(1'b0, '0, 1'b0, acc, pop);
        step(1'b0, '0, 1'b0, acc, pop);
        step(1'b1, 20'h33333, 1'b0, acc, pop);
        step(1'b1, 20'h44444, 1'b0, acc, pop);
        step(1'b1, 20'h55555, 1'b0, acc, pop);
        in_valid = 1'b0;
        check_model("mid_pre");
        chk("mid_pre.occupancy", int'(occupancy), 5);
        #2;
        reset_n = 1'b0;
        #1;
        chk("mid.out_valid", int'(out_valid), 0);
        chk("mid.occupancy", int'(occupancy), 0);
        chk("mid.flying",    int'(message_flying), 0);
        chk("mid.in_ready",  int'(in_ready), 0);
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        mq.delete();
        cyc = 0;
        #1;
`ifdef SC_LINK_STATS_EN
        chk("mid.msg_count", int'(msg_count), 0);
`endif
        n_out = 0;
        for (int k = 0; k < 15; k++) begin
            check_model("post_rst");
            if (out_valid) n_out++;
            step(1'b0, '0, 1'b1, acc, pop);
        end
        chk("post_rst.emerged", n_out, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
